uart_rx_fifo_ctrl: RTL and testbench

Receive-side buffer controller for the UART. Sits between the receive state machine (which emits one `WE_RHR` strobe per completed character with data and error flags on `RD`) and the host register interface. Owns a first-word-fall-through FIFO, its pointers and occupancy count, overrun detection, the threshold interrupt, and the character-timeout timer that the host uses to drain partial FIFOs.

---
 rtl/uart_rx_fifo_ctrl.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_ctrl
// Description : UART receive-side buffer controller. First-word-fall-through
//               FIFO of 9-bit entries ({error, data[7:0]}), occupancy count,
//               sticky overrun flag, threshold interrupt and the character
//               timeout timer used by the host to drain a partially filled
//               FIFO.
//
// Ports       : Clk, Rst          clock, synchronous active-high reset
//               CE_16x            one-cycle enable at 16x the bit rate
//               Len/NumStop/ParEn frame format (sets the timeout limit)
//               RxIdle            receiver state machine is idle
//               WE_RHR, RD        write strobe and character from receiver
//               RE_RHR            host pop strobe
//               FIFO_Clr          flush FIFO and clear flags
//               RxThr             interrupt threshold select
//               RHR               head of FIFO (valid while RxRdy)
//               RxRdy/RxFull      not-empty / full
//               RxCnt             occupancy, 0..DEPTH
//               RxOvr             sticky overrun
//               RxInt             occupancy at or above threshold
//               RxTO              character timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  CE_16x,
  input  logic                  Len,
  input  logic                  NumStop,
  input  logic                  ParEn,
  input  logic                  RxIdle,
  input  logic                  WE_RHR,
  input  logic [8:0]            RD,
  input  logic                  RE_RHR,
  input  logic                  FIFO_Clr,
  input  logic [1:0]            RxThr,
  output logic [8:0]            RHR,
  output logic                  RxRdy,
  output logic                  RxFull,
  output logic [DEPTH_LOG2:0]   RxCnt,
  output logic                  RxOvr,
  output logic                  RxInt,
  output logic                  RxTO
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage (not reset) and control state
  logic [8:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2-1:0] rp_q, rp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovr_q, ovr_d;
  logic                  to_q, to_d;
  logic [9:0]            tmr_q, tmr_d;
  logic [8:0]            rhr_q, rhr_d;

  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovr_evt;
  logic [3:0]            frame_bits;
  logic [9:0]            to_limit;
  logic [CW-1:0]         thr_lvl;

  // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
  assign rd_acc  = RE_RHR && (cnt_q != '0);
  assign wr_acc  = WE_RHR && ((cnt_q != FULL_CNT) || rd_acc);
  assign ovr_evt = WE_RHR && (cnt_q == FULL_CNT) && !rd_acc;

  // Timeout limit is four character times: 64 ticks of CE_16x per frame bit.
  assign frame_bits = 4'd1 + (Len ? 4'd8 : 4'd7) + {3'b000, ParEn} + (NumStop ? 4'd2 : 4'd1);
  assign to_limit   = {frame_bits, 6'b00_0000};

  always_comb begin
    thr_lvl = CW'(1);
    case (RxThr)
      2'd0:    thr_lvl = CW'(1);
      2'd1:    thr_lvl = CW'(DEPTH / 4);
      2'd2:    thr_lvl = CW'(DEPTH / 2);
      default: thr_lvl = CW'(DEPTH - 2);
    endcase
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovr_d = ovr_q | ovr_evt;
    tmr_d = tmr_q;
    to_d  = to_q;
    rhr_d = rhr_q;

    if (wr_acc) wp_d = wp_q + 1'b1;
    if (rd_acc) rp_d = rp_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Timer restarts on any FIFO activity and stays parked while empty.
    if (rd_acc || wr_acc || (cnt_q == '0)) begin
      tmr_d = '0;
      to_d  = 1'b0;
    end else begin
      if (CE_16x && RxIdle && (tmr_q < to_limit)) tmr_d = tmr_q + 10'd1;
      // Compare against the next count so the flag registers on the same
      // edge the counter reaches the limit.
      to_d = to_q | (tmr_d >= to_limit);
    end

    // Next head: when the new read pointer lands on the slot being written
    // this cycle the array does not hold it yet, so bypass RD.
    // With nothing left to show, the last head is simply held.
    if (cnt_d != '0) begin
      if (wr_acc && (rp_d == wp_q)) rhr_d = RD;
      else                          rhr_d = mem_q[rp_d];
    end

    // Flush wins over any same-cycle read or write.
    if (FIFO_Clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
      tmr_d = '0;
      to_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      tmr_q <= '0;
      to_q  <= 1'b0;
      rhr_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      tmr_q <= tmr_d;
      to_q  <= to_d;
      rhr_q <= rhr_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_acc && !FIFO_Clr) mem_q[wp_q] <= RD;
  end

  assign RHR    = rhr_q;
  assign RxCnt  = cnt_q;
  assign RxRdy  = (cnt_q != '0);
  assign RxFull = (cnt_q == FULL_CNT);
  assign RxOvr  = ovr_q;
  assign RxTO   = to_q;
  assign RxInt  = (cnt_q >= thr_lvl);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo_ctrl
// Description : Self-checking bench for uart_rx_fifo_ctrl. A queue-based
//               model of the receive buffer is compared against the DUT on
//               every falling edge; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_ctrl;

  localparam int DL2 = 4;
  localparam int D   = 1 << DL2;

  logic         Clk = 1'b0;
  logic         Rst, CE_16x, Len, NumStop, ParEn, RxIdle;
  logic         WE_RHR, RE_RHR, FIFO_Clr;
  logic [8:0]   RD;
  logic [1:0]   RxThr;
  logic [8:0]   RHR;
  logic         RxRdy, RxFull, RxOvr, RxInt, RxTO;
  logic [DL2:0] RxCnt;

  always #5 Clk = ~Clk;

  uart_rx_fifo_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .Clk(Clk), .Rst(Rst), .CE_16x(CE_16x), .Len(Len), .NumStop(NumStop),
    .ParEn(ParEn), .RxIdle(RxIdle), .WE_RHR(WE_RHR), .RD(RD),
    .RE_RHR(RE_RHR), .FIFO_Clr(FIFO_Clr), .RxThr(RxThr), .RHR(RHR),
    .RxRdy(RxRdy), .RxFull(RxFull), .RxCnt(RxCnt), .RxOvr(RxOvr),
    .RxInt(RxInt), .RxTO(RxTO)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Behavioural model state
  logic [8:0] mq[$];
  bit         m_ovr, m_to;
  int         m_tmr;

  logic [8:0] fv [16];

  function automatic int lvl(input logic [1:0] t);
    case (t)
      2'd0:    return 1;
      2'd1:    return D / 4;
      2'd2:    return D / 2;
      default: return D - 2;
    endcase
  endfunction

  function automatic int limit_ticks();
    return 64 * (1 + (Len ? 8 : 7) + (ParEn ? 1 : 0) + (NumStop ? 2 : 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Applies the inputs as they stood at the clock edge just taken.
  function automatic void model_step();
    bit rd, wr;
    int lim;
    if (Rst || FIFO_Clr) begin
      mq.delete();
      m_ovr = 0;
      m_to  = 0;
      m_tmr = 0;
    end else begin
      lim = limit_ticks();
      rd  = RE_RHR && (mq.size() > 0);
      wr  = WE_RHR && ((mq.size() < D) || rd);
      if (WE_RHR && !wr) m_ovr = 1;
      if (rd || wr || mq.size() == 0) begin
        m_tmr = 0;
        m_to  = 0;
      end else begin
        if (CE_16x && RxIdle && m_tmr < lim) m_tmr++;
        if (m_tmr >= lim) m_to = 1;
      end
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(RD);
    end
  endfunction

  task automatic compare_all();
    chk("cnt",  32'(RxCnt),  mq.size());
    chk("rdy",  32'(RxRdy),  32'(mq.size() > 0));
    chk("full", 32'(RxFull), 32'(mq.size() == D));
    chk("int",  32'(RxInt),  32'(mq.size() >= lvl(RxThr)));
    chk("ovr",  32'(RxOvr),  32'(m_ovr));
    chk("to",   32'(RxTO),   32'(m_to));
    if (mq.size() > 0) chk("rhr", 32'(RHR), 32'(mq[0]));
  endtask

  task automatic cyc(input bit we, input logic [8:0] d, input bit re, input bit clr);
    WE_RHR   = we;
    RD       = d;
    RE_RHR   = re;
    FIFO_Clr = clr;
    @(posedge Clk);
    model_step();
    #1;
    WE_RHR   = 1'b0;
    RE_RHR   = 1'b0;
    FIFO_Clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 9'h000, 0, 0);
  endtask

  initial begin
    int we_pm [3];
    int re_pm [3];
    int ce_pc [3];
    we_pm = '{500, 300, 1};
    re_pm = '{300, 600, 1};
    ce_pc = '{50, 50, 100};

    for (int i = 0; i < 16; i++) fv[i] = 9'((i * 37 + 16) % 512);

    // Compare process: checks the model on every falling edge.
    fork
      forever begin
        @(negedge Clk);
        if (chk_en) compare_all();
      end
    join_none

    Rst = 1; CE_16x = 0; Len = 1; NumStop = 0; ParEn = 1; RxIdle = 0;
    WE_RHR = 0; RE_RHR = 0; FIFO_Clr = 0; RD = 9'h000; RxThr = 2'd0;

    // Reset and basic write/read
    cyc(0, 9'h000, 0, 0);
    chk_en = 1;
    cyc(0, 9'h000, 0, 0);
    Rst = 0;
    chk("rst_cnt", 32'(RxCnt), 0);
    chk("rst_rhr", 32'(RHR), 32'h000);
    chk("rst_flags", {RxRdy, RxFull, RxOvr, RxInt, RxTO}, 0);

    cyc(1, 9'h041, 0, 0);
    cyc(1, 9'h142, 0, 0);
    chk("wr2_cnt", 32'(RxCnt), 2);
    chk("wr2_rdy", 32'(RxRdy), 1);
    chk("wr2_rhr", 32'(RHR), 32'h041);
    cyc(0, 9'h000, 1, 0);
    chk("pop1_rhr", 32'(RHR), 32'h142);
    cyc(0, 9'h000, 1, 0);
    chk("pop2_rdy", 32'(RxRdy), 0);
    chk("pop2_cnt", 32'(RxCnt), 0);

    // Fill with threshold sweep
    RxThr = 2'd2;
    for (int i = 0; i < 16; i++) begin
      cyc(1, fv[i], 0, 0);
      if (i == 0) begin
        RxThr = 2'd0; #1; chk("thr0_c1", 32'(RxInt), 1); RxThr = 2'd2;
      end
      if (i == 6)  chk("thr2_c7", 32'(RxInt), 0);
      if (i == 7)  chk("thr2_c8", 32'(RxInt), 1);
      if (i == 12) begin
        RxThr = 2'd3; #1; chk("thr3_c13", 32'(RxInt), 0); RxThr = 2'd2;
      end
      if (i == 13) begin
        RxThr = 2'd3; #1; chk("thr3_c14", 32'(RxInt), 1); RxThr = 2'd2;
      end
    end
    chk("fill_full", 32'(RxFull), 1);

    // Simultaneous write+pop while full
    cyc(1, 9'h1AA, 1, 0);
    chk("fullrw_cnt", 32'(RxCnt), 16);
    chk("fullrw_ovr", 32'(RxOvr), 0);
    chk("fullrw_rhr", 32'(RHR), 32'(fv[1]));

    // Overrun
    cyc(1, 9'h0FF, 0, 0);
    chk("ovr_set", 32'(RxOvr), 1);
    chk("ovr_cnt", 32'(RxCnt), 16);
    for (int i = 1; i < 16; i++) begin
      chk("drain_rhr", 32'(RHR), 32'(fv[i]));
      cyc(0, 9'h000, 1, 0);
    end
    chk("drain_tail", 32'(RHR), 32'h1AA);
    cyc(0, 9'h000, 1, 0);
    chk("drain_cnt", 32'(RxCnt), 0);
    chk("ovr_sticky", 32'(RxOvr), 1);
    cyc(0, 9'h000, 0, 1);
    chk("ovr_clr", 32'(RxOvr), 0);

    // Simultaneous write+pop while empty
    cyc(1, 9'h033, 1, 0);
    chk("emptyrw_cnt", 32'(RxCnt), 1);
    chk("emptyrw_rhr", 32'(RHR), 32'h033);

    // Character timeout: Len=1, ParEn=1, NumStop=0 -> 704 ticks
    CE_16x = 1; RxIdle = 1;
    idle(700);
    chk("to_700", 32'(RxTO), 0);
    RxIdle = 0;
    idle(10);
    chk("to_hold", 32'(RxTO), 0);
    RxIdle = 1;
    idle(3);
    chk("to_703", 32'(RxTO), 0);
    idle(1);
    chk("to_704", 32'(RxTO), 1);
    cyc(0, 9'h000, 1, 0);
    chk("to_pop", 32'(RxTO), 0);
    chk("to_pop_cnt", 32'(RxCnt), 0);
    CE_16x = 0;

    // Flush priority: 5 entries, overrun and timeout both set
    for (int i = 0; i < 16; i++) cyc(1, fv[i], 0, 0);
    cyc(1, 9'h0FF, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 9'h000, 1, 0);
    CE_16x = 1;
    idle(704);
    chk("fl_pre_cnt", 32'(RxCnt), 5);
    chk("fl_pre_flags", {RxOvr, RxTO}, 32'b11);
    cyc(1, 9'h155, 0, 1);
    chk("fl_cnt", 32'(RxCnt), 0);
    chk("fl_flags", {RxRdy, RxFull, RxOvr, RxInt, RxTO}, 0);
    idle(1);
    chk("fl_discard", 32'(RxCnt), 0);

    // Randomized phases
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 499) == 0) begin
          Len     = 1'($urandom);
          NumStop = 1'($urandom);
          ParEn   = 1'($urandom);
        end
        RxThr  = 2'($urandom);
        CE_16x = ($urandom_range(0, 99) < ce_pc[p]);
        RxIdle = ($urandom_range(0, 99) < 90);
        Rst    = ($urandom_range(0, 2999) == 0);
        cyc($urandom_range(0, 999) < we_pm[p], 9'($urandom),
            $urandom_range(0, 999) < re_pm[p], $urandom_range(0, 1999) == 0);
      end
    end
    Rst = 0;
    idle(2);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
